dh_shared_key_engine: RTL and testbench
=======================================

Name: dh_shared_key_engine

Overview:
Responder-side Diffie-Hellman shared-secret engine. It accepts the peer's public value plus the local private exponent and modulus, and computes KEY = PEER^X mod P. The exponentiation is a sequential, constant-time square-and-always-multiply ladder built on a bit-serial interleaved modular multiplier. It sits after the public-value exchange in the key-exchange subsystem, consuming the value the initiator side produced.

Parameters:
W, 32, operand width of PEER, X, P and KEY.

Ports:
CLK    input   1   system clock, rising edge.
RST    input   1   asynchronous, active-low reset.
ST     input   1   start request; accepted when ST=1 and BUSY=0.
PEER   input   W   peer public value; any value, including values >= P.
X      input   W   local private exponent.
P      input   W   modulus.
BUSY   output  1   high from the accepting edge until KEY_ACK completes.
KEY    output  W   shared secret; valid while KEY_VLD=1.
KEY_VLD output 1   result valid; held until acknowledged.
ERR    output  1   qualifies KEY_VLD; 1 = invalid modulus (P<2), KEY=0.
KEY_ACK input  1   result consumed; sampled only while KEY_VLD=1.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; BUSY=0, KEY=0, KEY_VLD=0, ERR=0; all internal registers cleared. Reset mid-computation aborts the operation with no output. Operation resumes on the first edge after RST deasserts.
- Accept: on an edge with ST=1 and BUSY=0, register PEER, X and P; BUSY=1 from that edge. ST is ignored while BUSY=1, so a held-high ST never restarts a running computation.
- States: IDLE -> CHECK -> REDUCE -> SQUARE <-> MULT -> DONE -> IDLE.
- CHECK (1 cycle):
  - If P<2: go to DONE with KEY=0, ERR=1.
  - Else: go to REDUCE; RES=1.
- Modular multiply MM(a,b):
  - Exactly W cycles, multiplier b scanned MSB first.
  - Each cycle: acc = 2*acc + (b[i] ? a : 0), then conditionally subtract P up to twice, so acc < P after each step.
  - acc width W+2; the acc<P invariant guarantees 2*acc+a < 3P.
  - Requires a < P.
- REDUCE (W cycles): BASE = MM(PEER mod-input, 1). This must yield PEER mod P; to meet MM's a<P precondition, the implementation performs an equivalent W-cycle shift-subtract reduction of PEER instead. Result BASE < P.
- Ladder, for each bit of X from MSB to LSB:
  - SQUARE (W cycles): RES = MM(RES,RES).
  - MULT (W cycles): T = MM(RES,BASE); RES = X[bit] ? T : RES.
  - The multiply always executes (constant time, no data-dependent latency).
  - W bit iterations total.
- DONE: KEY=RES, KEY_VLD=1, ERR as set, BUSY=1. KEY and ERR stay stable until an edge with KEY_ACK=1; on that edge KEY_VLD=0, BUSY=0, KEY holds its last value, state=IDLE. KEY_ACK while KEY_VLD=0 is ignored.
- Latency (accepting edge to KEY_VLD=1):
  - Valid P: exactly 1 + W + 2*W*W edges (2081 for W=32).
  - P<2: exactly 1 edge.
- Accept-after-ack: a new ST can be accepted no earlier than the edge after the KEY_ACK edge.
- Boundaries:
  - X=0 -> KEY=1 (P>=2), full latency.
  - PEER=0 or PEER mod P=0 -> KEY=0.
  - PEER=P -> KEY=0.
  - P=2^W-1 must not overflow: acc is W+2 bits and comparisons are at full width.
  - Input changes after accept have no effect.

Test Plan:
1. Reset and basic result: RST low then high; ST=1, PEER=17, X=6, P=5 -> KEY=4, ERR=0, KEY_VLD rises exactly 2081 cycles after the accept edge; KEY_ACK then BUSY=0.
2. RFC-style vector: PEER=8, X=15, P=23 -> KEY=2. Also PEER=19, X=6, P=23 -> KEY=2 (both ends agree).
3. Large modulus: PEER=2, X=32, P=32'hFFFFFFFB -> KEY=5. PEER=32'hFFFFFFFF, X=1, P=32'hFFFFFFFB -> KEY=4.
4. Degenerate inputs:
   - P=1 -> ERR=1, KEY=0, latency 1.
   - P=0 -> same.
   - X=0, P=23 -> KEY=1 at full latency.
   - PEER=46, P=23 -> KEY=0.
5. Handshake:
   - Keep ST high through a full run: exactly one accept.
   - Delay KEY_ACK by 10 cycles: KEY and KEY_VLD are held.
   - KEY_ACK pulsed while idle: no effect.
   - Change PEER mid-run: result unchanged.
6. Reset mid-run: assert RST at cycle 1000 of a run -> all outputs 0 immediately (asynchronous); after release, a new ST with PEER=8, X=15, P=23 -> KEY=2.

Source files
------------

// File: rtl/dh_shared_key_engine_if.sv
// Request/result bundle for the DH shared-key engine. The requester drives the
// operands, ST and KEY_ACK. The engine returns BUSY, KEY, KEY_VLD and ERR.
interface dh_shared_key_engine_if #(
    parameter int W = 32
);
    logic         ST;
    logic [W-1:0] PEER;
    logic [W-1:0] X;
    logic [W-1:0] P;
    logic         BUSY;
    logic [W-1:0] KEY;
    logic         KEY_VLD;
    logic         ERR;
    logic         KEY_ACK;

    modport master (
        output ST, PEER, X, P, KEY_ACK,
        input  BUSY, KEY, KEY_VLD, ERR
    );

    modport slave (
        input  ST, PEER, X, P, KEY_ACK,
        output BUSY, KEY, KEY_VLD, ERR
    );
endinterface

// File: rtl/dh_shared_key_engine.sv
// Computes KEY = PEER^X mod P in constant time. It uses a square-and-always-multiply
// ladder over a bit-serial interleaved modular multiplier.
module dh_shared_key_engine #(
    parameter int W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    dh_shared_key_engine_if.slave bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_REDUCE, S_SQUARE, S_MULT, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  peer_q, peer_d, x_q, x_d, p_q, p_d;
    logic [W-1:0]  base_q, base_d, res_q, res_d, key_q, key_d;
    logic [W+1:0]  acc_q, acc_d;
    logic [CW-1:0] cyc_q, cyc_d, exp_q, exp_d;
    logic          busy_q, busy_d, key_vld_q, key_vld_d, err_q, err_d;

    logic [CW-1:0] bidx, eidx;
    logic          last_cyc;
    logic [W+1:0]  add_v, p_ext, t0, t1, t2;

    assign bidx     = CW'(W - 1) - cyc_q;
    assign eidx     = CW'(W - 1) - exp_q;
    assign last_cyc = (cyc_q == CW'(W - 1));

    // REDUCE feeds one PEER bit per cycle into the same double-and-subtract step.
    // That reduces PEER mod P without needing PEER < P.
    always_comb begin
        add_v = '0;
        case (state_q)
            S_REDUCE: add_v = {{(W+1){1'b0}}, peer_q[bidx]};
            S_SQUARE: add_v = res_q[bidx] ? {2'b00, res_q}  : '0;
            S_MULT:   add_v = res_q[bidx] ? {2'b00, base_q} : '0;
            default:  add_v = '0;
        endcase
    end

    // Since acc < P, 2*acc + a < 3P, so two conditional subtracts restore acc < P.
    assign p_ext = {2'b00, p_q};
    assign t0    = (acc_q << 1) + add_v;
    assign t1    = (t0 >= p_ext) ? t0 - p_ext : t0;
    assign t2    = (t1 >= p_ext) ? t1 - p_ext : t1;

    always_comb begin
        state_d   = state_q;
        peer_d    = peer_q;
        x_d       = x_q;
        p_d       = p_q;
        base_d    = base_q;
        res_d     = res_q;
        key_d     = key_q;
        acc_d     = acc_q;
        cyc_d     = cyc_q;
        exp_d     = exp_q;
        busy_d    = busy_q;
        key_vld_d = key_vld_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ST) begin
                    peer_d  = bus.PEER;
                    x_d     = bus.X;
                    p_d     = bus.P;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                acc_d = '0;
                cyc_d = '0;
                exp_d = '0;
                if (p_q < W'(2)) begin
                    key_d     = '0;
                    err_d     = 1'b1;
                    key_vld_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    err_d   = 1'b0;
                    res_d   = W'(1);
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE, S_SQUARE, S_MULT: begin
                acc_d = t2;
                cyc_d = cyc_q + CW'(1);
                if (last_cyc) begin
                    acc_d = '0;
                    cyc_d = '0;
                    if (state_q == S_REDUCE) begin
                        base_d  = t2[W-1:0];
                        state_d = S_SQUARE;
                    end else if (state_q == S_SQUARE) begin
                        res_d   = t2[W-1:0];
                        state_d = S_MULT;
                    end else begin
                        if (x_q[eidx]) res_d = t2[W-1:0];
                        if (exp_q == CW'(W - 1)) begin
                            key_d     = x_q[eidx] ? t2[W-1:0] : res_q;
                            key_vld_d = 1'b1;
                            state_d   = S_DONE;
                        end else begin
                            exp_d   = exp_q + CW'(1);
                            state_d = S_SQUARE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (bus.KEY_ACK) begin
                    key_vld_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            peer_q    <= '0;
            x_q       <= '0;
            p_q       <= '0;
            base_q    <= '0;
            res_q     <= '0;
            key_q     <= '0;
            acc_q     <= '0;
            cyc_q     <= '0;
            exp_q     <= '0;
            busy_q    <= 1'b0;
            key_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            peer_q    <= peer_d;
            x_q       <= x_d;
            p_q       <= p_d;
            base_q    <= base_d;
            res_q     <= res_d;
            key_q     <= key_d;
            acc_q     <= acc_d;
            cyc_q     <= cyc_d;
            exp_q     <= exp_d;
            busy_q    <= busy_d;
            key_vld_q <= key_vld_d;
            err_q     <= err_d;
        end
    end

    assign bus.BUSY    = busy_q;
    assign bus.KEY     = key_q;
    assign bus.KEY_VLD = key_vld_q;
    assign bus.ERR     = err_q;
endmodule

// File: tb/tb_dh_shared_key_engine.sv
// Bench for dh_shared_key_engine. It runs directed and random exponentiations and
// checks them against a plain-arithmetic modular-power reference model.
module tb_dh_shared_key_engine;
    localparam int W       = 32;
    localparam int FULL_LAT = 1 + W + 2 * W * W;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    dh_shared_key_engine_if #(.W(W)) bus ();

    dh_shared_key_engine #(.W(W)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mod_pow(input logic [31:0] b, input logic [31:0] e,
                                            input logic [31:0] m);
        longint unsigned r, bb, mm, ee;
        if (m < 2) return 32'd0;
        mm = 64'(m);
        bb = 64'(b) % mm;
        ee = 64'(e);
        r  = 1;
        for (int i = 0; i < 32; i++) begin
            if (ee[0]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
            ee = ee >> 1;
        end
        return r[31:0];
    endfunction

    task automatic run_op(input logic [31:0] pr, input logic [31:0] xv, input logic [31:0] pv,
                          input int ack_dly, input bit hold_st, input bit perturb);
        logic [31:0] exp_key, k0;
        int          lat, exp_lat;
        exp_key = mod_pow(pr, xv, pv);
        exp_lat = (pv < 2) ? 1 : FULL_LAT;
        @(negedge clk);
        bus.ST   = 1'b1;
        bus.PEER = pr;
        bus.X    = xv;
        bus.P    = pv;
        @(posedge clk);
        #1;
        chk("busy_on_accept", 64'(bus.BUSY), 64'd1);
        if (!hold_st) bus.ST = 1'b0;
        if (perturb) begin
            bus.PEER = $urandom;
            bus.X    = $urandom;
            bus.P    = $urandom;
        end
        lat = 0;
        while (!bus.KEY_VLD && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("key", 64'(bus.KEY), 64'(exp_key));
        chk("err", 64'(bus.ERR), (pv < 2) ? 64'd1 : 64'd0);
        k0 = bus.KEY;
        repeat (ack_dly) @(posedge clk);
        if (ack_dly > 0) begin
            #1;
            chk("vld_held", 64'(bus.KEY_VLD), 64'd1);
            chk("key_held", 64'(bus.KEY), 64'(k0));
        end
        bus.KEY_ACK = 1'b1;
        @(posedge clk);
        #1;
        bus.KEY_ACK = 1'b0;
        bus.ST      = 1'b0;
        chk("vld_after_ack", 64'(bus.KEY_VLD), 64'd0);
        chk("busy_after_ack", 64'(bus.BUSY), 64'd0);
        if (hold_st) begin
            @(posedge clk);
            #1;
            chk("no_reaccept", 64'(bus.BUSY), 64'd0);
            chk("key_kept", 64'(bus.KEY), 64'(exp_key));
        end
    endtask

    initial begin
        logic [31:0] rp, rx, rpv;
        vectors     = 0;
        miscompares = 0;
        bus.ST      = 1'b0;
        bus.PEER    = '0;
        bus.X       = '0;
        bus.P       = '0;
        bus.KEY_ACK = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.BUSY), 64'd0);
        chk("rst_key", 64'(bus.KEY), 64'd0);
        chk("rst_vld", 64'(bus.KEY_VLD), 64'd0);
        chk("rst_err", 64'(bus.ERR), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd17, 32'd6, 32'd5, 0, 1'b0, 1'b0);
        run_op(32'd8, 32'd15, 32'd23, 0, 1'b0, 1'b0);
        run_op(32'd19, 32'd6, 32'd23, 0, 1'b0, 1'b0);
        run_op(32'd2, 32'd32, 32'hFFFFFFFB, 0, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFB, 0, 1'b0, 1'b0);
        run_op(32'd77, 32'd5, 32'd1, 0, 1'b0, 1'b0);
        run_op(32'd77, 32'd5, 32'd0, 0, 1'b0, 1'b0);
        run_op(32'd9, 32'd0, 32'd23, 0, 1'b0, 1'b0);
        run_op(32'd46, 32'd7, 32'd23, 0, 1'b0, 1'b0);
        run_op(32'd23, 32'd7, 32'd23, 0, 1'b0, 1'b0);
        run_op(32'd5, 32'd9, 32'hFFFFFFFF, 0, 1'b1, 1'b0);
        run_op(32'd8, 32'd15, 32'd23, 10, 1'b0, 1'b1);

        @(negedge clk);
        bus.KEY_ACK = 1'b1;
        @(posedge clk);
        #1;
        bus.KEY_ACK = 1'b0;
        chk("idle_ack_vld", 64'(bus.KEY_VLD), 64'd0);
        chk("idle_ack_busy", 64'(bus.BUSY), 64'd0);

        @(negedge clk);
        bus.ST   = 1'b1;
        bus.PEER = 32'd123;
        bus.X    = 32'hDEADBEEF;
        bus.P    = 32'd1009;
        @(posedge clk);
        #1;
        bus.ST = 1'b0;
        repeat (999) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.BUSY), 64'd0);
        chk("midrst_key", 64'(bus.KEY), 64'd0);
        chk("midrst_vld", 64'(bus.KEY_VLD), 64'd0);
        chk("midrst_err", 64'(bus.ERR), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd8, 32'd15, 32'd23, 0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rp  = $urandom;
            rx  = $urandom;
            rpv = (i % 2 == 0) ? 32'($urandom_range(2, 5000)) : ($urandom | 32'h8000_0000);
            run_op(rp, rx, rpv, int'($urandom_range(0, 3)), 1'b0, 1'(i % 3 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
